pipe_exe_stage: RTL and testbench

PIPE_EXE_STAGE -- requirements
Module: pipe_exe_stage

---
 rtl/pipe_exe_stage.sv | 199 +++++++++++++++++++
 tb/tb_pipe_exe_stage.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exe_stage.sv
// rtl/pipe_exe_stage.sv - EXE pipeline stage with forwarding muxes, ALU and iterative multiplier
module pipe_exe_stage (
    input  logic        clock,
    input  logic        resetn,
    input  logic        d_wreg,
    input  logic        d_m2reg,
    input  logic        d_wmem,
    input  logic [4:0]  d_aluc,
    input  logic [1:0]  d_adepen,
    input  logic [1:0]  d_bdepen,
    input  logic [31:0] d_qa,
    input  logic [31:0] d_qb,
    input  logic [31:0] d_imm,
    input  logic [4:0]  d_rn,
    input  logic        d_bubble,
    input  logic [31:0] m_fwd,
    input  logic [31:0] w_fwd,
    output logic        e_wreg,
    output logic        e_m2reg,
    output logic        e_wmem,
    output logic [4:0]  e_rn,
    output logic [31:0] e_alu,
    output logic [31:0] e_store,
    output logic        e_busy
);

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b01000;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b01010;
    localparam logic [4:0] ALU_XOR = 5'b01011;
    localparam logic [4:0] ALU_SLL = 5'b00101;
    localparam logic [4:0] ALU_SRL = 5'b01101;
    localparam logic [4:0] ALU_SRA = 5'b11101;
    localparam logic [4:0] ALU_LUI = 5'b00100;
    localparam logic [4:0] ALU_MUL = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    logic        r_wreg;
    logic        r_m2reg;
    logic        r_wmem;
    logic [4:0]  r_aluc;
    logic [1:0]  r_adepen;
    logic [1:0]  r_bdepen;
    logic [31:0] r_qa;
    logic [31:0] r_qb;
    logic [31:0] r_imm;
    logic [4:0]  r_rn;

    mul_state_t  state_q;
    mul_state_t  state_d;
    logic [4:0]  cnt_q;
    logic [31:0] mul_a_q;
    logic [31:0] mul_b_q;
    logic [31:0] prod_q;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic        is_mul;

    assign is_mul = (r_aluc == ALU_MUL);

    // ID/EXE register: held while busy; a bubble clears the whole slot so it produces no result
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wreg   <= 1'b0;
            r_m2reg  <= 1'b0;
            r_wmem   <= 1'b0;
            r_aluc   <= 5'd0;
            r_adepen <= 2'd0;
            r_bdepen <= 2'd0;
            r_qa     <= 32'd0;
            r_qb     <= 32'd0;
            r_imm    <= 32'd0;
            r_rn     <= 5'd0;
        end else if (!e_busy) begin
            if (d_bubble) begin
                r_wreg   <= 1'b0;
                r_m2reg  <= 1'b0;
                r_wmem   <= 1'b0;
                r_aluc   <= 5'd0;
                r_adepen <= 2'd0;
                r_bdepen <= 2'd0;
                r_qa     <= 32'd0;
                r_qb     <= 32'd0;
                r_imm    <= 32'd0;
                r_rn     <= 5'd0;
            end else begin
                r_wreg   <= d_wreg;
                r_m2reg  <= d_m2reg;
                r_wmem   <= d_wmem;
                r_aluc   <= d_aluc;
                r_adepen <= d_adepen;
                r_bdepen <= d_bdepen;
                r_qa     <= d_qa;
                r_qb     <= d_qb;
                r_imm    <= d_imm;
                r_rn     <= d_rn;
            end
        end
    end

    // Operand selection uses the live forwarding buses
    always_comb begin
        op_a = r_qa;
        op_b = r_qb;
        case (r_adepen)
            2'b00:   op_a = r_qa;
            2'b01:   op_a = {27'd0, r_imm[10:6]};
            2'b10:   op_a = m_fwd;
            default: op_a = w_fwd;
        endcase
        case (r_bdepen)
            2'b00:   op_b = r_qb;
            2'b01:   op_b = r_imm;
            2'b10:   op_b = m_fwd;
            default: op_b = w_fwd;
        endcase
    end

    // Single-cycle ALU; unknown opcodes give zero
    always_comb begin
        alu_res = 32'd0;
        case (r_aluc)
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_SLL: alu_res = op_b << op_a[4:0];
            ALU_SRL: alu_res = op_b >> op_a[4:0];
            ALU_SRA: alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
            ALU_LUI: alu_res = op_b << 16;
            default: alu_res = 32'd0;
        endcase
    end

    // Multiplier next-state and stall request
    always_comb begin
        state_d = state_q;
        e_busy  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    e_busy  = 1'b1;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                e_busy = 1'b1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Multiplier datapath: operands captured on entry so forwarding changes cannot disturb it
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            mul_a_q <= 32'd0;
            mul_b_q <= 32'd0;
            prod_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && is_mul) begin
                mul_a_q <= op_a;
                mul_b_q <= op_b;
                prod_q  <= 32'd0;
                cnt_q   <= 5'd0;
            end else if (state_q == ST_MUL) begin
                if (mul_b_q[0]) begin
                    prod_q <= prod_q + mul_a_q;
                end
                mul_a_q <= mul_a_q << 1;
                mul_b_q <= mul_b_q >> 1;
                cnt_q   <= cnt_q + 5'd1;
            end
        end
    end

    assign e_wreg  = r_wreg  & ~e_busy;
    assign e_m2reg = r_m2reg & ~e_busy;
    assign e_wmem  = r_wmem  & ~e_busy;
    assign e_rn    = r_rn;
    assign e_store = r_qb;
    assign e_alu   = is_mul ? prod_q : alu_res;

endmodule

// File: tb/tb_pipe_exe_stage.sv
// tb/tb_pipe_exe_stage.sv - directed self-checking bench for pipe_exe_stage
module tb_pipe_exe_stage;

    logic        clock;
    logic        resetn;
    logic        d_wreg;
    logic        d_m2reg;
    logic        d_wmem;
    logic [4:0]  d_aluc;
    logic [1:0]  d_adepen;
    logic [1:0]  d_bdepen;
    logic [31:0] d_qa;
    logic [31:0] d_qb;
    logic [31:0] d_imm;
    logic [4:0]  d_rn;
    logic        d_bubble;
    logic [31:0] m_fwd;
    logic [31:0] w_fwd;
    logic        e_wreg;
    logic        e_m2reg;
    logic        e_wmem;
    logic [4:0]  e_rn;
    logic [31:0] e_alu;
    logic [31:0] e_store;
    logic        e_busy;

    int checks;
    int errors;

    pipe_exe_stage dut (
        .clock    (clock),
        .resetn   (resetn),
        .d_wreg   (d_wreg),
        .d_m2reg  (d_m2reg),
        .d_wmem   (d_wmem),
        .d_aluc   (d_aluc),
        .d_adepen (d_adepen),
        .d_bdepen (d_bdepen),
        .d_qa     (d_qa),
        .d_qb     (d_qb),
        .d_imm    (d_imm),
        .d_rn     (d_rn),
        .d_bubble (d_bubble),
        .m_fwd    (m_fwd),
        .w_fwd    (w_fwd),
        .e_wreg   (e_wreg),
        .e_m2reg  (e_m2reg),
        .e_wmem   (e_wmem),
        .e_rn     (e_rn),
        .e_alu    (e_alu),
        .e_store  (e_store),
        .e_busy   (e_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [4:0] aluc, input logic [1:0] asel, input logic [1:0] bsel,
                          input logic [31:0] qa, input logic [31:0] qb, input logic [31:0] imm,
                          input logic wreg);
        d_aluc   = aluc;
        d_adepen = asel;
        d_bdepen = bsel;
        d_qa     = qa;
        d_qb     = qb;
        d_imm    = imm;
        d_wreg   = wreg;
        d_m2reg  = 1'b0;
        d_wmem   = 1'b0;
        d_rn     = 5'd3;
        d_bubble = 1'b0;
    endtask

    // Counts stall cycles starting from the current (already busy) sample; flags any MEM control leak
    task automatic measure_busy(input logic poke_fwd, output int n, output logic leak);
        n = 0;
        leak = 1'b0;
        while (e_busy && n < 100) begin
            if (e_wreg || e_m2reg || e_wmem) leak = 1'b1;
            n++;
            if (poke_fwd && n == 5) m_fwd = 32'd0;
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_op(5'd0, 2'd0, 2'd0, 32'd9, 32'd9, 32'd0, 1'b1);
        m_fwd = 32'd0;
        w_fwd = 32'd0;
        tick();
        tick();
        checks++;
        if ({e_wreg, e_m2reg, e_wmem, e_busy} !== 4'b0000 || e_alu !== 32'd0 || e_store !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ctl=%b busy=%b alu=%h store=%h, required all zero",
                     {e_wreg, e_m2reg, e_wmem}, e_busy, e_alu, e_store);
        end
        #2 resetn = 1'b1;
    endtask

    task automatic test_add();
        set_op(5'b00000, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'd12 || e_wreg !== 1'b1 || e_store !== 32'd7 || e_rn !== 5'd3) begin
            errors++;
            $display("FAIL add: alu=%h wreg=%b store=%h rn=%0d, required alu=0000000c wreg=1 store=7 rn=3",
                     e_alu, e_wreg, e_store, e_rn);
        end
    endtask

    task automatic test_sub_fwd();
        m_fwd = 32'h10;
        set_op(5'b01000, 2'b10, 2'b00, 32'd0, 32'd1, 32'd0, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'h0F) begin
            errors++;
            $display("FAIL sub_mfwd: alu=%h, required 0000000f", e_alu);
        end
        w_fwd = 32'd3;
        set_op(5'b01000, 2'b11, 2'b00, 32'd0, 32'd1, 32'd0, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'd2) begin
            errors++;
            $display("FAIL sub_wfwd: alu=%h, required 00000002", e_alu);
        end
        w_fwd = 32'd10;
        #1;
        checks++;
        if (e_alu !== 32'd9) begin
            errors++;
            $display("FAIL sub_wfwd_live: alu=%h, required 00000009", e_alu);
        end
    endtask

    task automatic test_shift_lui();
        set_op(5'b11101, 2'b01, 2'b00, 32'd0, 32'h80000000, 32'h00000100, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'hF8000000) begin
            errors++;
            $display("FAIL sra: alu=%h, required f8000000", e_alu);
        end
        set_op(5'b01101, 2'b01, 2'b00, 32'd0, 32'h80000000, 32'h00000100, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'h08000000) begin
            errors++;
            $display("FAIL srl: alu=%h, required 08000000", e_alu);
        end
        set_op(5'b00100, 2'b00, 2'b01, 32'd0, 32'd0, 32'h1234, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'h12340000) begin
            errors++;
            $display("FAIL lui: alu=%h, required 12340000", e_alu);
        end
        set_op(5'b01011, 2'b00, 2'b00, 32'hF0F0_1234, 32'h0FF0_1234, 32'd0, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'hFF00_0000) begin
            errors++;
            $display("FAIL xor: alu=%h, required ff000000", e_alu);
        end
        set_op(5'b11111, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 1'b1);
        tick();
        checks++;
        if (e_alu !== 32'd0) begin
            errors++;
            $display("FAIL bad_opcode: alu=%h, required 00000000", e_alu);
        end
    endtask

    task automatic test_bubble();
        set_op(5'b00000, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 1'b1);
        d_wmem  = 1'b1;
        d_m2reg = 1'b1;
        tick();
        d_bubble = 1'b1;
        tick();
        checks++;
        if ({e_wreg, e_m2reg, e_wmem} !== 3'b000 || e_alu !== 32'd0) begin
            errors++;
            $display("FAIL bubble: ctl=%b alu=%h, required ctl=000 alu=00000000",
                     {e_wreg, e_m2reg, e_wmem}, e_alu);
        end
    endtask

    task automatic test_mul();
        int   n;
        logic leak;
        m_fwd = 32'hFFFFFFFF;
        set_op(5'b00001, 2'b10, 2'b01, 32'd0, 32'd0, 32'd3, 1'b1);
        tick();
        d_bubble = 1'b1;
        measure_busy(1'b1, n, leak);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL mul_busy_cycles: busy=%0d, required 33", n);
        end
        checks++;
        if (leak !== 1'b0) begin
            errors++;
            $display("FAIL mul_ctl_bubble: leak=%b, required 0", leak);
        end
        checks++;
        if (e_alu !== 32'hFFFFFFFD || e_wreg !== 1'b1) begin
            errors++;
            $display("FAIL mul_result: alu=%h wreg=%b, required fffffffd wreg=1", e_alu, e_wreg);
        end
        tick();
        checks++;
        if (e_busy !== 1'b0 || e_alu !== 32'd0) begin
            errors++;
            $display("FAIL mul_exit: busy=%b alu=%h, required busy=0 alu=00000000", e_busy, e_alu);
        end
    endtask

    task automatic test_back_to_back();
        int   n;
        logic leak;
        set_op(5'b00001, 2'b00, 2'b00, 32'd6, 32'd7, 32'd0, 1'b1);
        tick();
        measure_busy(1'b0, n, leak);
        checks++;
        if (n !== 33 || e_alu !== 32'd42) begin
            errors++;
            $display("FAIL b2b_first: busy=%0d alu=%h, required 33 and 0000002a", n, e_alu);
        end
        set_op(5'b00001, 2'b00, 2'b00, 32'd5, 32'd5, 32'd0, 1'b1);
        tick();
        checks++;
        if (e_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b, required 1", e_busy);
        end
        d_bubble = 1'b1;
        measure_busy(1'b0, n, leak);
        checks++;
        if (n !== 33 || e_alu !== 32'd25 || leak !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: busy=%0d alu=%h leak=%b, required 33, 00000019, 0", n, e_alu, leak);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        set_op(5'b00001, 2'b00, 2'b00, 32'd1234, 32'd99, 32'd0, 1'b1);
        tick();
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (e_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_mul_busy: busy=%b, required 1", e_busy);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (e_busy !== 1'b0 || e_alu !== 32'd0 || {e_wreg, e_m2reg, e_wmem} !== 3'b000 || e_store !== 32'd0) begin
            errors++;
            $display("FAIL mid_mul_reset: busy=%b alu=%h ctl=%b store=%h, required all zero",
                     e_busy, e_alu, {e_wreg, e_m2reg, e_wmem}, e_store);
        end
        set_op(5'b00000, 2'b00, 2'b00, 32'd5, 32'd7, 32'd0, 1'b1);
        tick();
        #2 resetn = 1'b1;
        tick();
        checks++;
        if (e_busy !== 1'b0 || e_alu !== 32'd12 || e_wreg !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_add: busy=%b alu=%h wreg=%b, required 0, 0000000c, 1",
                     e_busy, e_alu, e_wreg);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub_fwd();
        test_shift_lui();
        test_bubble();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
